gpu_command_decoder: RTL

Parametrised successor to the GPU instruction decoder. It accepts 4-bit-opcode command words over a valid/ready handshake and maintains shadow registers for xy1, xy2 and radius. Each accepted draw command is snapshotted into a FIFO of complete draw instructions, which the rasteriser front-end pops with its own valid/ready handshake. New over the previous generation: parametrised geometry, colour and parameter widths; backpressure; buffering; a shadow-clear opcode; illegal-opcode detection; and a synchronous flush.

---
 rtl/gpu_pkg.sv | 35 +++
 rtl/gpu_instr_fifo.sv | 81 ++++++++
 rtl/gpu_command_decoder.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// gpu_pkg: shared opcode encoding, default widths and the draw-instruction
// bundle used by the GPU command decoder and its instruction FIFO.
package gpu_pkg;

    localparam int GPU_WIDTH_BITS   = 10;
    localparam int GPU_HEIGHT_BITS  = 9;
    localparam int GPU_CHANNEL_BITS = 8;
    localparam int GPU_PARAM_BITS   = 28;
    localparam int GPU_FIFO_DEPTH   = 4;

    typedef enum logic [3:0] {
        OP_CLR    = 4'd0,
        OP_XY1    = 4'd1,
        OP_XY2    = 4'd2,
        OP_RAD    = 4'd3,
        OP_LINE   = 4'd4,
        OP_RECT   = 4'd5,
        OP_CIRCLE = 4'd6,
        OP_ARC    = 4'd7
    } gpu_op_t;

    typedef struct packed {
        logic [3:0]                  op;
        logic [GPU_WIDTH_BITS-1:0]   x1;
        logic [GPU_HEIGHT_BITS-1:0]  y1;
        logic [GPU_WIDTH_BITS-1:0]   x2;
        logic [GPU_HEIGHT_BITS-1:0]  y2;
        logic [GPU_WIDTH_BITS-1:0]   rad;
        logic [GPU_CHANNEL_BITS-1:0] b;
        logic [GPU_CHANNEL_BITS-1:0] g;
        logic [GPU_CHANNEL_BITS-1:0] r;
        logic [2:0]                  oct;
    } draw_instr_t;

endpackage

// File: rtl/gpu_instr_fifo.sv
// gpu_instr_fifo: synchronous FIFO of draw instructions with flush.
// Ports: clk/rst, push_i+din_i, pop_i, flush_i, dout_o (head), full_o,
// empty_o, count_o.
module gpu_instr_fifo
    import gpu_pkg::*;
#(
    parameter int  DEPTH = GPU_FIFO_DEPTH,
    parameter type T     = draw_instr_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  T                       din_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output T                       dout_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    T              r_mem [DEPTH];
    T              r_last;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_full;

    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_count_nxt;

    assign empty_o = (r_count == '0);
    assign full_o  = r_full;
    assign count_o = r_count;

    // Head holds its last shown value while empty.
    assign dout_o  = empty_o ? r_last : r_mem[r_rd_ptr];

    assign w_push = push_i && !r_full && !flush_i;
    assign w_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        w_count_nxt = r_count;
        if (flush_i)
            w_count_nxt = '0;
        else
            w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
            r_last   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            r_last  <= dout_o;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            if (flush_i) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_mem[r_wr_ptr] <= din_i;
                    r_wr_ptr        <= r_wr_ptr + 1'b1;
                end
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpu_command_decoder.sv
// gpu_command_decoder: decodes command words into shadow xy1/xy2/rad and
// buffers snapshotted draw instructions for the rasteriser.
// Ports: cmd_valid_i/cmd_ready_o/opcode_i/parameters_i command handshake,
// flush_i, instr_valid_o/instr_ready_i plus head fields opcode_o..b_o,
// reg_write_o and illegal_o pulses, count_o buffered entries.
module gpu_command_decoder
    import gpu_pkg::*;
#(
    parameter int WIDTH_BITS   = GPU_WIDTH_BITS,
    parameter int HEIGHT_BITS  = GPU_HEIGHT_BITS,
    parameter int CHANNEL_BITS = GPU_CHANNEL_BITS,
    parameter int PARAM_BITS   = GPU_PARAM_BITS,
    parameter int FIFO_DEPTH   = GPU_FIFO_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid_i,
    output logic                        cmd_ready_o,
    input  logic [3:0]                  opcode_i,
    input  logic [PARAM_BITS-1:0]       parameters_i,
    input  logic                        flush_i,
    output logic                        instr_valid_o,
    input  logic                        instr_ready_i,
    output logic [3:0]                  opcode_o,
    output logic [WIDTH_BITS-1:0]       x1_o,
    output logic [HEIGHT_BITS-1:0]      y1_o,
    output logic [WIDTH_BITS-1:0]       x2_o,
    output logic [HEIGHT_BITS-1:0]      y2_o,
    output logic [WIDTH_BITS-1:0]       rad_o,
    output logic [2:0]                  oct_o,
    output logic [CHANNEL_BITS-1:0]     r_o,
    output logic [CHANNEL_BITS-1:0]     g_o,
    output logic [CHANNEL_BITS-1:0]     b_o,
    output logic                        reg_write_o,
    output logic                        illegal_o,
    output logic [$clog2(FIFO_DEPTH):0] count_o
);

    localparam int W = WIDTH_BITS;
    localparam int H = HEIGHT_BITS;
    localparam int C = CHANNEL_BITS;

    typedef struct packed {
        logic [3:0]   op;
        logic [W-1:0] x1;
        logic [H-1:0] y1;
        logic [W-1:0] x2;
        logic [H-1:0] y2;
        logic [W-1:0] rad;
        logic [C-1:0] b;
        logic [C-1:0] g;
        logic [C-1:0] r;
        logic [2:0]   oct;
    } instr_t;

    logic [W-1:0] r_x1, r_x2, r_rad;
    logic [H-1:0] r_y1, r_y2;
    logic         r_live;
    logic         r_reg_write;
    logic         r_illegal;

    logic         w_full;
    logic         w_empty;
    logic         w_accept;
    logic         w_push;
    logic         w_pop;
    logic [W-1:0] w_px;
    logic [H-1:0] w_py;
    instr_t       w_din;
    instr_t       w_head;

    // r_live keeps ready low while reset is held.
    assign cmd_ready_o = r_live && !w_full;
    assign w_accept    = cmd_valid_i && cmd_ready_o;
    assign w_push      = w_accept && (opcode_i[3:2] == 2'b01);
    assign w_pop       = instr_valid_o && instr_ready_i;

    assign w_px = parameters_i[W-1:0];
    assign w_py = parameters_i[W+H-1:W];

    always_comb begin
        w_din     = '0;
        w_din.op  = opcode_i;
        w_din.x1  = r_x1;
        w_din.y1  = r_y1;
        w_din.x2  = r_x2;
        w_din.y2  = r_y2;
        w_din.rad = r_rad;
        w_din.b   = parameters_i[C-1:0];
        w_din.g   = parameters_i[2*C-1:C];
        w_din.r   = parameters_i[3*C-1:2*C];
        if (opcode_i == OP_ARC)
            w_din.oct = parameters_i[PARAM_BITS-1 -: 3];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x1        <= '0;
            r_y1        <= '0;
            r_x2        <= '0;
            r_y2        <= '0;
            r_rad       <= '0;
            r_live      <= 1'b0;
            r_reg_write <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_live      <= 1'b1;
            r_reg_write <= w_accept && !opcode_i[3];
            r_illegal   <= w_accept && opcode_i[3];
            if (w_accept) begin
                unique case (opcode_i)
                    OP_CLR: begin
                        r_x1  <= '0;
                        r_y1  <= '0;
                        r_x2  <= '0;
                        r_y2  <= '0;
                        r_rad <= '0;
                    end
                    OP_XY1: begin
                        r_x1 <= w_px;
                        r_y1 <= w_py;
                    end
                    OP_XY2: begin
                        r_x2 <= w_px;
                        r_y2 <= w_py;
                    end
                    OP_RAD: r_rad <= w_px;
                    default: ;
                endcase
            end
        end
    end

    gpu_instr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (instr_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .din_i   (w_din),
        .pop_i   (w_pop),
        .flush_i (flush_i),
        .dout_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (count_o)
    );

    assign instr_valid_o = !w_empty;
    assign opcode_o      = w_head.op;
    assign x1_o          = w_head.x1;
    assign y1_o          = w_head.y1;
    assign x2_o          = w_head.x2;
    assign y2_o          = w_head.y2;
    assign rad_o         = w_head.rad;
    assign oct_o         = w_head.oct;
    assign r_o           = w_head.r;
    assign g_o           = w_head.g;
    assign b_o           = w_head.b;
    assign reg_write_o   = r_reg_write;
    assign illegal_o     = r_illegal;

endmodule
